// File: rtl/pipe_step_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// pipe_step_ctrl_pkg
// Shared definitions for the run/step sequencer of the 5-stage RISC-V core:
// datapath width, the default debounce length, the cycle-counter width and
// the fixed FSM state encoding. The state encoding is shown on the board's
// debug display, so its values must not change.
// Ports: none (package).
// -----------------------------------------------------------------------------
package pipe_step_ctrl_pkg;

    localparam int XLEN_DEF            = 32;
    localparam int DEBOUNCE_CYCLES_DEF = 500000;
    localparam int CNT_W_DEF           = 32;

    typedef enum logic [1:0] {
        S_HALT  = 2'd0,
        S_RUN   = 2'd1,
        S_BURST = 2'd2,
        S_BREAK = 2'd3
    } state_t;

    // A burst length of zero on the switches still means one step.
    function automatic logic [3:0] burst_len(input logic [3:0] n);
        return (n == 4'd0) ? 4'd1 : n;
    endfunction

endpackage

// File: rtl/pipe_step_ctrl_if.sv
// -----------------------------------------------------------------------------
// pipe_step_ctrl_if
// Bundle between the sequencer and the core / debug display.
//   pc, bp_addr   : fetch PC from the core and the breakpoint address
//   step          : pipeline advance enable to the core
//   halted        : sequencer is in HALT or BREAK
//   bp_hit        : one-cycle pulse when a breakpoint is taken
//   cycle_count   : number of cycles with step=1
//   state         : current FSM state for the debug display
// Modports: master = sequencer side, slave = core side.
// -----------------------------------------------------------------------------
interface pipe_step_ctrl_if
    import pipe_step_ctrl_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int CNT_W = CNT_W_DEF
);

    logic [XLEN-1:0]  pc;
    logic [XLEN-1:0]  bp_addr;
    logic             step;
    logic             halted;
    logic             bp_hit;
    logic [CNT_W-1:0] cycle_count;
    state_t           state;

    modport master (
        input  pc, bp_addr,
        output step, halted, bp_hit, cycle_count, state
    );

    modport slave (
        output pc, bp_addr,
        input  step, halted, bp_hit, cycle_count, state
    );

endinterface

// File: rtl/pipe_step_ctrl_key_debounce.sv
// -----------------------------------------------------------------------------
// key_debounce
// One active-low push button: 2-FF synchroniser, stable-level counter and a
// falling-edge press pulse. The accepted level only changes once the
// synchronised key has held the new value for DEBOUNCE_CYCLES consecutive
// cycles; an accepted 1->0 change yields a single-cycle press pulse.
// Ports:
//   clock, reset : system clock, synchronous active-high reset
//   key_n        : raw active-low key from the board
//   press        : one-cycle pulse per accepted press (release gives nothing)
// -----------------------------------------------------------------------------
module key_debounce
    import pipe_step_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic clock,
    input  logic reset,
    input  logic key_n,
    output logic press
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_q, sync2_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          level_q, level_d;
    logic          level_prev_q;
    logic          press_q, press_d;

    always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        // Any sample equal to the accepted level restarts the count.
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
        press_d = level_prev_q & ~level_q;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sync1_q      <= 1'b1;
            sync2_q      <= 1'b1;
            cnt_q        <= '0;
            level_q      <= 1'b1;
            level_prev_q <= 1'b1;
            press_q      <= 1'b0;
        end else begin
            sync1_q      <= key_n;
            sync2_q      <= sync1_q;
            cnt_q        <= cnt_d;
            level_q      <= level_d;
            level_prev_q <= level_q;
            press_q      <= press_d;
        end
    end

    assign press = press_q;

endmodule

// File: rtl/pipe_step_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_step_ctrl
// Run/step sequencer for the 5-stage RISC-V pipeline. Debounces the board
// keys and drives the core's step enable, which gates PC and pipeline
// register advance. Modes: free run, single/N-step burst, and a PC
// breakpoint that freezes the pipeline before the matching fetch.
// Ports:
//   clock, reset : system clock, synchronous active-high reset
//   key[1:0]     : active-low keys, key[0]=step, key[1]=run/halt toggle
//   switch[9:0]  : switch[3:0]=burst length, switch[9]=auto-run after reset
//   core         : pipe_step_ctrl_if.master (pc, bp_addr in; step, halted,
//                  bp_hit, cycle_count, state out)
// Build option: define PIPE_STEP_BREAKPOINT_EN to include the breakpoint
// logic. Without it bp_hit is 0, BREAK is unreachable and pc/bp_addr are
// ignored (the ports stay for a stable interface).
// -----------------------------------------------------------------------------
module pipe_step_ctrl
    import pipe_step_ctrl_pkg::*;
#(
    parameter int XLEN            = XLEN_DEF,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int CNT_W           = CNT_W_DEF
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [1:0]       key,
    input  logic [9:0]       switch,
    pipe_step_ctrl_if.master core
);

    logic             step_press, run_press;
    state_t           state_q, state_d;
    logic [3:0]       remain_q, remain_d;
    logic [CNT_W-1:0] cycle_count_q, cycle_count_d;
    logic             take_bp;
    logic             bp_match;
    logic             step_o, halted_o;
    logic [XLEN-1:0]  pc_w, bp_w;
    logic             unused_sw;

    assign pc_w      = core.pc;
    assign bp_w      = core.bp_addr;
    assign unused_sw = ^switch[8:4];

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_step (
        .clock (clock),
        .reset (reset),
        .key_n (key[0]),
        .press (step_press)
    );

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_run (
        .clock (clock),
        .reset (reset),
        .key_n (key[1]),
        .press (run_press)
    );

`ifdef PIPE_STEP_BREAKPOINT_EN
    logic bp_armed_q, bp_armed_d;
    logic bp_hit_q;

    assign bp_match = bp_armed_q && (pc_w == bp_w);

    // Leaving BREAK disarms so the core can fetch past the breakpoint; the
    // first cycle with pc away from bp_addr re-arms it.
    always_comb begin
        bp_armed_d = bp_armed_q;
        if ((state_q == S_BREAK) && (run_press || step_press)) begin
            bp_armed_d = 1'b0;
        end else if (pc_w != bp_w) begin
            bp_armed_d = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            bp_armed_q <= 1'b1;
            bp_hit_q   <= 1'b0;
        end else begin
            bp_armed_q <= bp_armed_d;
            bp_hit_q   <= take_bp;
        end
    end

    assign core.bp_hit = bp_hit_q;
`else
    logic unused_bp;

    assign bp_match    = 1'b0;
    assign unused_bp   = ^{pc_w, bp_w, take_bp};
    assign core.bp_hit = 1'b0;
`endif

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= switch[9] ? S_RUN : S_HALT;
            remain_q      <= 4'd0;
            cycle_count_q <= '0;
        end else begin
            state_q       <= state_d;
            remain_q      <= remain_d;
            cycle_count_q <= cycle_count_d;
        end
    end

    // Next-state logic; run_press is checked first so a simultaneous
    // step_press is dropped.
    always_comb begin
        state_d  = state_q;
        remain_d = remain_q;
        take_bp  = 1'b0;
        unique case (state_q)
            S_HALT: begin
                if (run_press) begin
                    state_d = S_RUN;
                end else if (step_press) begin
                    state_d  = S_BURST;
                    remain_d = burst_len(switch[3:0]);
                end
            end
            S_RUN: begin
                if (bp_match) begin
                    state_d = S_BREAK;
                    take_bp = 1'b1;
                end else if (run_press) begin
                    state_d = S_HALT;
                end
            end
            S_BURST: begin
                if (bp_match) begin
                    state_d  = S_BREAK;
                    take_bp  = 1'b1;
                    remain_d = 4'd0;
                end else if (run_press) begin
                    state_d  = S_HALT;
                    remain_d = 4'd0;
                end else if (remain_q == 4'd1) begin
                    state_d  = S_HALT;
                    remain_d = 4'd0;
                end else begin
                    remain_d = remain_q - 4'd1;
                end
            end
            S_BREAK: begin
                if (run_press) begin
                    state_d = S_RUN;
                end else if (step_press) begin
                    state_d  = S_BURST;
                    remain_d = burst_len(switch[3:0]);
                end
            end
            default: state_d = S_HALT;
        endcase
    end

    // Outputs: pure decode of the current state, plus the step counter
    always_comb begin
        step_o        = ((state_q == S_RUN) || (state_q == S_BURST)) && !bp_match;
        halted_o      = (state_q == S_HALT) || (state_q == S_BREAK);
        cycle_count_d = cycle_count_q + CNT_W'(step_o);
    end

    assign core.step        = step_o;
    assign core.halted      = halted_o;
    assign core.cycle_count = cycle_count_q;
    assign core.state       = state_q;

endmodule

// File: tb/tb_pipe_step_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipe_step_ctrl
// Directed and randomised stimulus for pipe_step_ctrl with DEBOUNCE_CYCLES=4.
// A behavioural model (sample-window debounce, burst step budget, breakpoint
// rules) predicts every output each cycle; the bench also plays the core by
// advancing pc by 4 on every cycle the model says step=1.
// -----------------------------------------------------------------------------
module tb_pipe_step_ctrl;

    localparam int D = 4;
    localparam logic [1:0] M_HALT = 2'd0, M_RUN = 2'd1, M_BURST = 2'd2, M_BRK = 2'd3;
    localparam logic [31:0] FAR_BP = 32'hFFFF_FFF0;

    logic       clock = 1'b0;
    logic       reset;
    logic [1:0] key;
    logic [9:0] switch;

    pipe_step_ctrl_if #(.XLEN(32), .CNT_W(32)) bus ();

    pipe_step_ctrl #(.XLEN(32), .DEBOUNCE_CYCLES(D), .CNT_W(32)) dut (
        .clock  (clock),
        .reset  (reset),
        .key    (key),
        .switch (switch),
        .core   (bus)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    // Model state
    logic [1:0]  m_state = M_HALT;
    int          m_left  = 0;
    bit          m_armed = 1'b1;
    bit          m_hit   = 1'b0;
    logic [31:0] m_cnt   = '0;
    bit [15:0]   m_khist [2];
    bit          m_lvl [2];
    bit          m_lvl_prev [2];
    bit          m_press [2];
    logic [31:0] pc_next = '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit m_match();
`ifdef PIPE_STEP_BREAKPOINT_EN
        return m_armed && (bus.pc == bus.bp_addr);
`else
        return 1'b0;
`endif
    endfunction

    function automatic bit m_step();
        return ((m_state == M_RUN) || (m_state == M_BURST)) && !m_match();
    endfunction

    // Advance the model across one clock edge using the inputs present now.
    task automatic model_advance();
        bit runp, stepp, stp, match, flip, new_press;
        int n;
        runp  = m_press[1];
        stepp = m_press[0];
        match = m_match();
        stp   = m_step();
        n     = (switch[3:0] == 4'd0) ? 1 : int'(switch[3:0]);
        if (reset) begin
            m_state = switch[9] ? M_RUN : M_HALT;
            m_left  = 0;
            m_armed = 1'b1;
            m_cnt   = '0;
            m_hit   = 1'b0;
            for (int k = 0; k < 2; k++) begin
                m_khist[k]    = '1;
                m_lvl[k]      = 1'b1;
                m_lvl_prev[k] = 1'b1;
                m_press[k]    = 1'b0;
            end
            pc_next = '0;
            return;
        end
        // Debounce: the level flips when the D synchronised samples ending
        // two edges back all disagree with it; the press shows one edge later.
        for (int k = 0; k < 2; k++) begin
            m_khist[k] = {m_khist[k][14:0], key[k]};
            flip = 1'b1;
            for (int b = 2; b <= D + 1; b++) begin
                if (m_khist[k][b] == m_lvl[k]) flip = 1'b0;
            end
            new_press     = m_lvl_prev[k] && !m_lvl[k];
            m_lvl_prev[k] = m_lvl[k];
            if (flip) m_lvl[k] = !m_lvl[k];
            m_press[k] = new_press;
        end
        pc_next = stp ? bus.pc + 32'd4 : bus.pc;
        if (stp) m_cnt = m_cnt + 32'd1;
        if ((m_state == M_BRK) && (runp || stepp)) m_armed = 1'b0;
        else if (bus.pc != bus.bp_addr) m_armed = 1'b1;
        m_hit = 1'b0;
        case (m_state)
            M_HALT: begin
                if (runp) m_state = M_RUN;
                else if (stepp) begin m_state = M_BURST; m_left = n; end
            end
            M_RUN: begin
                if (match) begin m_state = M_BRK; m_hit = 1'b1; end
                else if (runp) m_state = M_HALT;
            end
            M_BURST: begin
                if (match) begin m_state = M_BRK; m_hit = 1'b1; m_left = 0; end
                else if (runp) begin m_state = M_HALT; m_left = 0; end
                else begin
                    m_left--;
                    if (m_left == 0) m_state = M_HALT;
                end
            end
            default: begin
                if (runp) m_state = M_RUN;
                else if (stepp) begin m_state = M_BURST; m_left = n; end
            end
        endcase
    endtask

    task automatic cycle();
        model_advance();
        @(posedge clock);
        #1;
        bus.pc = pc_next;
        #1;
        chk("state", bus.state, m_state);
        chk("halted", bus.halted, ((m_state == M_HALT) || (m_state == M_BRK)));
        chk("step", bus.step, m_step());
        chk("bp_hit", bus.bp_hit, m_hit);
        chk("cycle_count", bus.cycle_count, m_cnt);
    endtask

    initial begin
        int first_step, steps, runs, hits;
        bit step_at_bp;
        key         = 2'b11;
        switch      = '0;
        reset       = 1'b1;
        bus.pc      = '0;
        bus.bp_addr = FAR_BP;

        // Reset into HALT and sit idle
        cycle(); cycle();
        reset = 1'b0;
        for (int i = 0; i < 50; i++) cycle();
        chk("idle_state", bus.state, M_HALT);
        chk("idle_halted", bus.halted, 1'b1);
        chk("idle_step", bus.step, 1'b0);
        chk("idle_count", bus.cycle_count, 32'd0);

        // Burst of 3 from a 10-cycle step press
        switch[3:0] = 4'd3;
        key[0]      = 1'b0;
        first_step  = -1;
        steps       = 0;
        for (int i = 1; i <= 30; i++) begin
            if (i == 11) key[0] = 1'b1;
            cycle();
            if (bus.step && first_step < 0) first_step = i;
            steps += int'(bus.step);
        end
        chk("burst_latency", first_step, 8);
        chk("burst_steps", steps, 3);
        chk("burst_end_state", bus.state, M_HALT);
        chk("burst_count", bus.cycle_count, 32'd3);

        // 3-cycle glitch is shorter than the debounce window
        key[0] = 1'b0;
        steps  = 0;
        for (int i = 0; i < 18; i++) begin
            if (i == 3) key[0] = 1'b1;
            cycle();
            steps += int'(bus.step);
        end
        chk("glitch_steps", steps, 0);
        chk("glitch_count", bus.cycle_count, 32'd3);

        // Auto-run after reset, then halt with the run key
        switch = 10'h200;
        reset  = 1'b1;
        cycle();
        reset = 1'b0;
        chk("autorun_state", bus.state, M_RUN);
        chk("autorun_step", bus.step, 1'b1);
        runs = int'(bus.step);
        for (int i = 0; i < 30; i++) begin
            if (i == 5)  key[1] = 1'b0;
            if (i == 13) key[1] = 1'b1;
            cycle();
            runs += int'(bus.step);
        end
        chk("autorun_halt", bus.state, M_HALT);
        chk("autorun_count", bus.cycle_count, 32'(runs));

        // Both keys together from HALT: run wins, no burst
        switch = 10'd2;
        reset  = 1'b1;
        cycle();
        reset = 1'b0;
        key   = 2'b00;
        for (int i = 0; i < 30; i++) begin
            if (i == 8) key = 2'b11;
            cycle();
        end
        chk("both_keys_state", bus.state, M_RUN);
        key[1] = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (i == 8) key[1] = 1'b1;
            cycle();
        end
        chk("both_keys_halt", bus.state, M_HALT);

        // Breakpoint at 0x0C while running with pc += 4
        switch      = '0;
        bus.bp_addr = 32'h0000_000C;
        reset       = 1'b1;
        cycle();
        reset      = 1'b0;
        key[1]     = 1'b0;
        hits       = 0;
        step_at_bp = 1'b1;
        for (int i = 0; i < 30; i++) begin
            if (i == 8) key[1] = 1'b1;
            cycle();
            hits += int'(bus.bp_hit);
            if (bus.pc == 32'h0000_000C && step_at_bp) step_at_bp = bus.step;
        end
`ifdef PIPE_STEP_BREAKPOINT_EN
        chk("bp_step_at_pc", step_at_bp, 1'b0);
        chk("bp_hits", hits, 1);
        chk("bp_state", bus.state, M_BRK);
        chk("bp_pc", bus.pc, 32'h0000_000C);
        switch[3:0] = 4'd1;
        key[0]      = 1'b0;
        hits        = 0;
        steps       = 0;
        for (int i = 0; i < 25; i++) begin
            if (i == 8) key[0] = 1'b1;
            cycle();
            hits  += int'(bus.bp_hit);
            steps += int'(bus.step);
        end
        chk("bp_resume_steps", steps, 1);
        chk("bp_resume_pc", bus.pc, 32'h0000_0010);
        chk("bp_resume_state", bus.state, M_HALT);
        chk("bp_resume_hits", hits, 0);
`else
        chk("nobp_hits", hits, 0);
        chk("nobp_state", bus.state, M_RUN);
        chk("nobp_pc_past", (bus.pc > 32'h0000_000C), 1'b1);
        key[1] = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (i == 8) key[1] = 1'b1;
            cycle();
        end
        chk("nobp_halt", bus.state, M_HALT);
`endif

        // Randomised phase: keys, burst length, resets and breakpoints
        for (int it = 0; it < 60; it++) begin
            int hold;
            hold        = $urandom_range(1, 10);
            key         = 2'($urandom_range(0, 3));
            switch[3:0] = 4'($urandom_range(0, 15));
            switch[9]   = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) bus.bp_addr = bus.pc + 32'(4 * $urandom_range(0, 5));
            else bus.bp_addr = FAR_BP;
            if ($urandom_range(0, 19) == 0) reset = 1'b1;
            for (int c = 0; c < hold; c++) begin
                cycle();
                reset = 1'b0;
            end
            key = 2'b11;
            for (int c = 0; c < 4; c++) cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipe_step_ctrl.md
Name: pipe_step_ctrl

Overview:
- Run/step sequencer for the 5-stage RISC-V pipeline.
- Debounces the board keys and drives the core's `step` enable, which gates advance of the PC and all pipeline registers.
- Supports free run, single-step and N-step burst modes, plus a PC breakpoint that freezes the pipeline before the matching instruction is fetched.
- Sits between the board I/O (key, switch) and RiscV_cpu.

Parameters:
XLEN, 32, datapath/PC width (from the shared include)
DEBOUNCE_CYCLES, 500000, consecutive stable cycles before a key level is accepted (bench uses 4)
CNT_W, 32, width of cycle_count

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
key  in  2  active-low push buttons; key[0] = step, key[1] = run/halt toggle
switch  in  10  switch[3:0] = burst length N; switch[9] = auto-run after reset
pc  in  XLEN  current fetch PC from the core
bp_addr  in  XLEN  breakpoint address
step  out  1  pipeline advance enable to RiscV_cpu
halted  out  1  1 when state is HALT or BREAK
bp_hit  out  1  1-cycle pulse when a breakpoint is taken
cycle_count  out  CNT_W  number of cycles with step=1
state  out  2  current FSM state, for debug display

Behaviour:
- Key path:
  - Each key passes through a 2-FF synchroniser, then a debounce counter.
  - The accepted level changes only after DEBOUNCE_CYCLES consecutive cycles of the new synchronised value.
  - A press is an accepted 1->0 transition. It produces a 1-cycle press pulse 2+DEBOUNCE_CYCLES+1 cycles after the key edge.
  - Release produces no event.
  - Accepted levels reset to 1 (released).
- States (encoding fixed in the include): S_HALT=0, S_RUN=1, S_BURST=2, S_BREAK=3.
- Reset:
  - state = switch[9] ? S_RUN : S_HALT.
  - remain=0, bp_armed=1, cycle_count=0, bp_hit=0.
  - Debounce counters are cleared.
  - step follows the state decode; reset mid-burst aborts the burst.
- bp_match = bp_armed && (pc == bp_addr).
- step (combinational) = (state==S_RUN || state==S_BURST) && !bp_match.
- Transitions, evaluated on the clock edge:
  - S_HALT:
    - run_press -> S_RUN.
    - step_press -> S_BURST, remain = (switch[3:0]==0) ? 1 : switch[3:0].
  - S_RUN:
    - bp_match -> S_BREAK with bp_hit=1.
    - else run_press -> S_HALT.
  - S_BURST:
    - bp_match -> S_BREAK with bp_hit=1 (burst discarded).
    - else run_press -> S_HALT (abort).
    - else if remain==1 -> S_HALT.
    - else remain -= 1.
    - step_press is ignored.
  - S_BREAK (step=0):
    - run_press -> S_RUN.
    - step_press -> S_BURST, loading remain.
    - Either exit clears bp_armed.
- bp_armed re-sets on the first cycle where pc != bp_addr. This lets execution move past a taken breakpoint.
- Simultaneous run_press and step_press: run_press wins and step_press is dropped.
- Burst of N yields exactly N step cycles unless interrupted.
- cycle_count += 1 on every cycle with step=1, wrapping modulo 2^CNT_W.
- halted = (state==S_HALT || state==S_BREAK), as a state decode with no latency.

Optional Feature:
- Macro: PIPE_STEP_BREAKPOINT_EN.
- Defined: breakpoint logic as described above.
- Undefined:
  - bp_match is tied 0, so S_BREAK is unreachable.
  - bp_hit is tied 0.
  - bp_addr and pc are unused; the ports remain for a stable interface.
  - bp_armed is removed.

Decomposition:
- The shared include holds XLEN, the state encodings S_HALT/S_RUN/S_BURST/S_BREAK and the default DEBOUNCE_CYCLES.
- Sub-module key_debounce: synchroniser, stable counter and falling-edge press pulse, parameterised by DEBOUNCE_CYCLES. It is instantiated twice (key[0], key[1]).

Test Plan (DEBOUNCE_CYCLES=4):
- Reset with switch=0, then hold key=2'b11 -> state=S_HALT, halted=1, step=0, cycle_count=0 for 50 cycles.
- switch[3:0]=3, pulse key[0] low for 10 cycles -> press pulse 7 cycles after the edge; step=1 for exactly 3 cycles; then S_HALT; cycle_count=3.
- key[0] glitches low for 3 cycles (< DEBOUNCE_CYCLES) -> no press, step stays 0.
- Reset with switch[9]=1 -> S_RUN immediately, step=1; press key[1] -> S_HALT, with cycle_count equal to the run cycles counted.
- Breakpoint, with the macro defined:
  - bp_addr=32'h0000000C, run with pc incrementing by 4 -> step=0 in the cycle pc=0x0C; bp_hit pulses once; state=S_BREAK.
  - Then press key[0] with N=1 -> exactly one step cycle past 0x0C, no re-break.
- Press key[0] and key[1] in the same cycle from S_HALT -> S_RUN, and no burst is loaded.
